// File: rtl/keccak_pkg.sv
// Shared Keccak/SHAKE constants, the word-count helper and the store-stage
// state encoding.
package keccak_pkg;

  localparam int w              = 64;
  localparam int RATE_SHAKE128  = 1344;
  localparam int RATE_SHAKE256  = 1088;
  localparam int WORDS_SHAKE128 = RATE_SHAKE128 / w;
  localparam int WORDS_SHAKE256 = RATE_SHAKE256 / w;
  localparam int WORD_CNT_W     = 5;

  localparam logic [1:0] SHAKE128_MODE_VEC = 2'b10;
  localparam logic [1:0] SHAKE256_MODE_VEC = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_BLOCK,
    ST_SHIFT,
    ST_FINISH
  } store_state_t;

  // Unknown modes fall back to the SHAKE128 rate.
  function automatic logic [WORD_CNT_W-1:0] words_per_block(input logic [1:0] mode);
    return (mode == SHAKE256_MODE_VEC) ? WORD_CNT_W'(WORDS_SHAKE256)
                                       : WORD_CNT_W'(WORDS_SHAKE128);
  endfunction

endpackage

// File: rtl/store_datapath_if.sv
// Bundle between the store stage and its neighbours: control from load_datapath,
// the permuted rate block, and the serial output stream.
interface store_datapath_if
  import keccak_pkg::*;
#(
    parameter int WIDTH_SIZE = 32
);
    logic                     start;
    logic [WIDTH_SIZE-1:0]    output_size;
    logic [1:0]               operation_mode;
    logic                     block_valid;
    logic [RATE_SHAKE128-1:0] block_in;
    logic                     block_ready;
    logic                     squeeze_req;
    logic [w-1:0]             data_out;
    logic                     data_out_valid;
    logic                     data_out_ready;
    logic                     data_out_last;
    logic                     done;
    logic                     busy;

    modport master (
        output start, output_size, operation_mode, block_valid, block_in, data_out_ready,
        input  block_ready, squeeze_req, data_out, data_out_valid, data_out_last, done, busy
    );

    modport slave (
        input  start, output_size, operation_mode, block_valid, block_in, data_out_ready,
        output block_ready, squeeze_req, data_out, data_out_valid, data_out_last, done, busy
    );
endinterface

// File: rtl/piso_buffer.sv
// Parallel-in serial-out word buffer: loads a whole block, then shifts it out
// one WIDTH-bit word per shift, lowest word first.
module piso_buffer #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 21
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_en_i,
    input  logic                   shift_en_i,
    input  logic [WIDTH*DEPTH-1:0] par_i,
    output logic [WIDTH-1:0]       ser_o
);
    logic [WIDTH*DEPTH-1:0] shreg_q;

    // NOTE: this wide register is reset on purpose: an abort must never leave
    // stale state words that could reappear on data_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
        end else if (load_en_i) begin
            shreg_q <= par_i;
        end else if (shift_en_i) begin
            shreg_q <= shreg_q >> WIDTH;
        end
    end

    assign ser_o = shreg_q[WIDTH-1:0];
endmodule

// File: rtl/store_datapath.sv
// SHAKE squeeze output stage: captures the permuted rate, serialises it into
// w-bit words and requests further permutations until the output length is met.
module store_datapath
  import keccak_pkg::*;
#(
    parameter int WIDTH_SIZE = 32
) (
    input  logic            clk,
    input  logic            rst,
    store_datapath_if.slave bus
);
    store_state_t          state_q, state_d;
    logic [WIDTH_SIZE-1:0] bits_left_q, bits_left_d;
    logic [WORD_CNT_W-1:0] wpb_q, wpb_d;
    logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic                  squeeze_q, squeeze_d;
    logic                  load_en, shift_en;
    logic                  is_last;
    logic [w-1:0]          piso_word;
    logic [6:0]            pad_shift;
    logic [w-1:0]          last_mask;

    assign is_last = (bits_left_q <= WIDTH_SIZE'(w));

    // NOTE: every variable gets its default before the case, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        bits_left_d = bits_left_q;
        wpb_d       = wpb_q;
        word_cnt_d  = word_cnt_q;
        squeeze_d   = 1'b0;
        load_en     = 1'b0;
        shift_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    bits_left_d = bus.output_size;
                    wpb_d       = words_per_block(bus.operation_mode);
                    state_d     = (bus.output_size == '0) ? ST_FINISH : ST_WAIT_BLOCK;
                end
            end
            ST_WAIT_BLOCK: begin
                if (bus.block_valid) begin
                    load_en    = 1'b1;
                    word_cnt_d = wpb_q;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bus.data_out_ready) begin
                    shift_en    = 1'b1;
                    word_cnt_d  = word_cnt_q - WORD_CNT_W'(1);
                    bits_left_d = is_last ? '0 : bits_left_q - WIDTH_SIZE'(w);
                    if (is_last) begin
                        state_d = ST_FINISH;
                    end else if (word_cnt_q == WORD_CNT_W'(1)) begin
                        squeeze_d = 1'b1;
                        state_d   = ST_WAIT_BLOCK;
                    end
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            bits_left_q <= '0;
            wpb_q       <= '0;
            word_cnt_q  <= '0;
            squeeze_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bits_left_q <= bits_left_d;
            wpb_q       <= wpb_d;
            word_cnt_q  <= word_cnt_d;
            squeeze_q   <= squeeze_d;
        end
    end

    piso_buffer #(
        .WIDTH(w),
        .DEPTH(RATE_SHAKE128 / w)
    ) u_piso (
        .clk       (clk),
        .rst_n     (rst),
        .load_en_i (load_en),
        .shift_en_i(shift_en),
        .par_i     (bus.block_in),
        .ser_o     (piso_word)
    );

    // Keep only the low bits_left bits of a partial final word.
    assign pad_shift = 7'(w) - bits_left_q[6:0];
    assign last_mask = is_last ? ({w{1'b1}} >> pad_shift) : {w{1'b1}};

    assign bus.block_ready    = (state_q == ST_WAIT_BLOCK);
    assign bus.data_out_valid = (state_q == ST_SHIFT);
    assign bus.data_out_last  = (state_q == ST_SHIFT) && is_last;
    assign bus.data_out       = (state_q == ST_SHIFT) ? (piso_word & last_mask) : '0;
    assign bus.squeeze_req    = squeeze_q;
    assign bus.done           = (state_q == ST_FINISH);
    assign bus.busy           = (state_q != ST_IDLE);
endmodule

// File: tb/tb_store_datapath.sv
// Directed bench for store_datapath: expected words come from a block-pattern
// generator and the requested output length.
module tb_store_datapath;
    import keccak_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    store_datapath_if #(.WIDTH_SIZE(32)) bus ();
    store_datapath #(.WIDTH_SIZE(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] blk_word(input int seed, input int i);
        return {16'(seed), 16'(i), 32'h9E37_79B9 ^ 32'(i * 32'h0100_0193)};
    endfunction

    function automatic logic [RATE_SHAKE128-1:0] make_block(input int seed);
        logic [RATE_SHAKE128-1:0] b;
        b = '0;
        for (int i = 0; i < RATE_SHAKE128 / 64; i++) b[i*64 +: 64] = blk_word(seed, i);
        return b;
    endfunction

    // Output monitor: collects handshaken words, counts pulses, checks stalls.
    logic [63:0] got_data[$];
    logic        got_last[$];
    int sq_cnt, done_cnt, done_cyc, last_hs_cyc, rdy_seen, val_seen, start_cyc;
    logic        hold_v = 1'b0;
    logic [63:0] hold_d;
    logic        hold_l;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            if (hold_v && bus.data_out_valid) begin
                check("stall_data", bus.data_out, hold_d);
                check("stall_last", 64'(bus.data_out_last), 64'(hold_l));
            end
            hold_v = bus.data_out_valid && !bus.data_out_ready;
            hold_d = bus.data_out;
            hold_l = bus.data_out_last;
            if (bus.data_out_valid && bus.data_out_ready) begin
                got_data.push_back(bus.data_out);
                got_last.push_back(bus.data_out_last);
                if (bus.data_out_last) last_hs_cyc = cyc;
            end
            if (bus.squeeze_req) sq_cnt++;
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.block_ready) rdy_seen++;
            if (bus.data_out_valid) val_seen++;
        end else begin
            hold_v = 1'b0;
        end
    end

    bit bp_en = 1'b0;
    initial forever begin
        @(posedge clk);
        #1;
        bus.data_out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic clear_mon();
        got_data.delete();
        got_last.delete();
        sq_cnt = 0; done_cnt = 0; done_cyc = 0; last_hs_cyc = 0;
        rdy_seen = 0; val_seen = 0;
    endtask

    task automatic do_start(input logic [1:0] mode, input int size);
        @(posedge clk);
        #1;
        bus.start          = 1'b1;
        bus.operation_mode = mode;
        bus.output_size    = 32'(size);
        start_cyc          = cyc;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic feed_block(input int seed, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (bus.block_ready) ok = 1'b1;
        end
        if (ok) begin
            bus.block_valid = 1'b1;
            bus.block_in    = make_block(seed);
            @(posedge clk);
            #1;
            bus.block_valid = 1'b0;
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(posedge clk);
            if (done_cnt > 0) ok = 1'b1;
        end
    endtask

    task automatic run_txn(input string tag, input logic [1:0] mode, input int size,
                           input int seed, input int wpb, input bit junk);
        int nwords, nblk, r;
        bit ok;
        logic [63:0] exp;
        nwords = (size + 63) / 64;
        nblk   = (nwords + wpb - 1) / wpb;
        clear_mon();
        do_start(mode, size);
        for (int b = 0; b < nblk; b++) begin
            feed_block(seed + b, ok);
            check({tag, "_block_ready"}, 64'(ok), 64'd1);
            if (!ok) break;
            if (junk && b == 0) begin
                // Junk offered while shifting must never be captured.
                bus.block_valid = 1'b1;
                bus.block_in    = make_block(16'hDEAD);
            end
        end
        wait_done(ok);
        check({tag, "_done_seen"}, 64'(ok), 64'd1);
        bus.block_valid = 1'b0;
        check({tag, "_nwords"}, 64'(got_data.size()), 64'(nwords));
        for (int k = 0; k < nwords && k < got_data.size(); k++) begin
            exp = blk_word(seed + k / wpb, k % wpb);
            r   = size % 64;
            if (k == nwords - 1 && r != 0) exp = exp & ((64'h1 << r) - 64'h1);
            check($sformatf("%s_w%0d", tag, k), got_data[k], exp);
            check($sformatf("%s_last%0d", tag, k), 64'(got_last[k]), 64'(k == nwords - 1));
        end
        check({tag, "_squeeze"}, 64'(sq_cnt), 64'(nblk - 1));
        check({tag, "_done_lat"}, 64'(done_cyc - last_hs_cyc), 64'd1);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        check({tag, "_idle"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 64'(bus.data_out_valid), 64'd0);
        check({tag, "_last"},  64'(bus.data_out_last), 64'd0);
        check({tag, "_data"},  bus.data_out, 64'd0);
        check({tag, "_bready"}, 64'(bus.block_ready), 64'd0);
        check({tag, "_sq"},    64'(bus.squeeze_req), 64'd0);
        check({tag, "_done"},  64'(bus.done), 64'd0);
        check({tag, "_busy"},  64'(bus.busy), 64'd0);
    endtask

    initial begin
        bit ok;
        bus.start          = 1'b0;
        bus.output_size    = '0;
        bus.operation_mode = SHAKE128_MODE_VEC;
        bus.block_valid    = 1'b0;
        bus.block_in       = '0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        run_txn("s128_256", SHAKE128_MODE_VEC, 256, 16'h0100, WORDS_SHAKE128, 1'b1);
        run_txn("s256_1152", SHAKE256_MODE_VEC, 1152, 16'h0200, WORDS_SHAKE256, 1'b0);
        run_txn("s128_100", SHAKE128_MODE_VEC, 100, 16'h0300, WORDS_SHAKE128, 1'b0);
        bp_en = 1'b1;
        run_txn("s128_bp", SHAKE128_MODE_VEC, 1344, 16'h0400, WORDS_SHAKE128, 1'b0);
        bp_en = 1'b0;
        run_txn("mode00_1408", 2'b00, 1408, 16'h0500, WORDS_SHAKE128, 1'b0);

        // Zero-length request: done without any block or word traffic.
        clear_mon();
        do_start(SHAKE128_MODE_VEC, 0);
        wait_done(ok);
        check("zero_done_seen", 64'(ok), 64'd1);
        check("zero_done_lat_le2", 64'((done_cyc - start_cyc) <= 2), 64'd1);
        check("zero_no_bready", 64'(rdy_seen), 64'd0);
        check("zero_no_valid", 64'(val_seen), 64'd0);

        // Abort in the middle of a block.
        clear_mon();
        do_start(SHAKE128_MODE_VEC, 1344);
        feed_block(16'h0600, ok);
        check("rst_block_ready", 64'(ok), 64'd1);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk);
            if (got_data.size() >= 5) ok = 1'b1;
        end
        check("rst_reach_w5", 64'(ok), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("rst_async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("rst_released");
        run_txn("after_rst", SHAKE128_MODE_VEC, 256, 16'h0700, WORDS_SHAKE128, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
